// File: rtl/serial_mag_comparator_ctrl_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   cmp_state_t    : controller FSM states
//   cmp_flags_t    : cascade flag bundle {fe, fl, fg}
//   WIDTH_DEFAULT  : default operand width
//   cascade_update : one MSB-first compare step, used by the slice cell
package serial_cmp_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } cmp_state_t;

  typedef struct packed {
    logic fe;
    logic fl;
    logic fg;
  } cmp_flags_t;

  // Once a higher bit has decided the order (fe=0), lower bits cannot change it.
  function automatic cmp_flags_t cascade_update(input logic ai, input logic bi,
                                                input cmp_flags_t f);
    cmp_flags_t r;
    r.fl = f.fl | (f.fe & ~ai & bi);
    r.fg = f.fg | (f.fe & ai & ~bi);
    r.fe = f.fe & ~(ai ^ bi);
    return r;
  endfunction

endpackage

// File: rtl/serial_mag_comparator_ctrl_if.sv
// Handshake/result bundle for serial_mag_comparator_ctrl.
//   start, a, b              : request and operands (master -> slave)
//   busy, done, lt, eq, gt   : status and result   (slave -> master)
interface serial_mag_comparator_ctrl_if #(
  parameter int WIDTH = serial_cmp_pkg::WIDTH_DEFAULT
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;

  modport master (output start, a, b, input busy, done, lt, eq, gt);
  modport slave  (input start, a, b, output busy, done, lt, eq, gt);
endinterface

// File: rtl/serial_mag_comparator_ctrl_slice.sv
// cmp_slice: combinational 1-bit magnitude-compare cascade cell.
//   ai, bi                  : operand bits at the current position
//   fe_in, fl_in, fg_in     : flags from the more significant bits
//   fe_out, fl_out, fg_out  : flags including this bit
module cmp_slice
  import serial_cmp_pkg::*;
(
  input  logic ai,
  input  logic bi,
  input  logic fe_in,
  input  logic fl_in,
  input  logic fg_in,
  output logic fe_out,
  output logic fl_out,
  output logic fg_out
);
  cmp_flags_t f_out;

  assign f_out  = cascade_update(ai, bi, '{fe: fe_in, fl: fl_in, fg: fg_in});
  assign fe_out = f_out.fe;
  assign fl_out = f_out.fl;
  assign fg_out = f_out.fg;
endmodule

// File: rtl/serial_mag_comparator_ctrl.sv
// serial_mag_comparator_ctrl: compares two WIDTH-bit operands MSB first, one
// bit per clock, through a single cmp_slice.
//   clk, rst_n  : clock (rising edge), async active-low reset
//   bus (slave) : start/a/b in; busy/done/lt/eq/gt out
// Optional macro SERIAL_CMP_EARLY_EXIT_EN: leave RUN as soon as the operands
// are known to differ. Undefined: fixed WIDTH-cycle RUN (constant time).
//
// state | meaning
// IDLE  | wait for start, capture a/b
// LOAD  | preset bit index and cascade flags
// RUN   | one bit per cycle through the slice
// FIN   | result registered, done pulse
module serial_mag_comparator_ctrl
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  serial_mag_comparator_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);

  cmp_state_t       state, state_nxt;
  logic [WIDTH-1:0] ra, rb;
  logic [IDX_W-1:0] idx;
  logic             fe, fl, fg;
  logic             fe_n, fl_n, fg_n;
  logic             lt_r, eq_r, gt_r;
  logic             last;

  cmp_slice u_slice (
    .ai     (ra[idx]),
    .bi     (rb[idx]),
    .fe_in  (fe),
    .fl_in  (fl),
    .fg_in  (fg),
    .fe_out (fe_n),
    .fl_out (fl_n),
    .fg_out (fg_n)
  );

  always_comb begin
    state_nxt = state;
    last      = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = LOAD;
      LOAD: state_nxt = RUN;
      RUN: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        last = (idx == '0) || !fe_n;
`else
        last = (idx == '0);
`endif
        if (last) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      idx   <= '0;
      fe    <= 1'b0;
      fl    <= 1'b0;
      fg    <= 1'b0;
      lt_r  <= 1'b0;
      eq_r  <= 1'b0;
      gt_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            ra <= bus.a;
            rb <= bus.b;
          end
        end
        LOAD: begin
          idx <= IDX_W'(WIDTH - 1);
          fe  <= 1'b1;
          fl  <= 1'b0;
          fg  <= 1'b0;
        end
        RUN: begin
          fe <= fe_n;
          fl <= fl_n;
          fg <= fg_n;
          // Result is loaded on the RUN->FIN edge so it is valid with done.
          if (last) begin
            lt_r <= fl_n;
            eq_r <= fe_n;
            gt_r <= fg_n;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == LOAD) || (state == RUN);
  assign bus.done = (state == FIN);
  assign bus.lt   = lt_r;
  assign bus.eq   = eq_r;
  assign bus.gt   = gt_r;
endmodule

// File: tb/tb_serial_mag_comparator_ctrl.sv
module tb_serial_mag_comparator_ctrl;
  import serial_cmp_pkg::*;

  localparam int W = 8;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam int LAT_GT   = 3;
  localparam int B2B_PER  = 8;
  localparam int B2B_NUM  = 4;
`else
  localparam int LAT_GT   = 10;
  localparam int B2B_PER  = 11;
  localparam int B2B_NUM  = 3;
`endif
  localparam int LAT_FULL = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  serial_mag_comparator_ctrl_if #(.WIDTH(W)) bus ();

  serial_mag_comparator_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start; cnt counts edges, the sampling edge is cnt=1.
  task automatic run_cmp(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int lat, output logic [2:0] res);
    lat = -1;
    res = 3'bxxx;
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    for (int cnt = 1; cnt <= 40; cnt++) begin
      tick();
      if (cnt == 1) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = cnt;
        res = {bus.lt, bus.eq, bus.gt};
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #2;
    tests++;
    if ({bus.busy, bus.done, bus.lt, bus.eq, bus.gt} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 00000",
               {bus.busy, bus.done, bus.lt, bus.eq, bus.gt});
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tests++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      fails++;
      $display("FAIL reset_idle: busy/done got %b want 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_equal();
    int lat;
    logic [2:0] res;
    run_cmp(8'hA5, 8'hA5, lat, res);
    tests++;
    if (lat !== LAT_FULL) begin
      fails++;
      $display("FAIL eq_latency: got %0d want %0d", lat, LAT_FULL);
    end
    tests++;
    if (res !== 3'b010) begin
      fails++;
      $display("FAIL eq_result: lt/eq/gt got %b want 010", res);
    end
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL eq_busy_at_done: got %b want 0", bus.busy);
    end
    tick();
    tests++;
    if (bus.done !== 1'b0 || {bus.lt, bus.eq, bus.gt} !== 3'b010) begin
      fails++;
      $display("FAIL eq_done_pulse: done=%b res=%b want done=0 res=010",
               bus.done, {bus.lt, bus.eq, bus.gt});
    end
  endtask

  task automatic test_greater();
    int lat;
    logic [2:0] res;
    run_cmp(8'h80, 8'h7F, lat, res);
    tests++;
    if (lat !== LAT_GT) begin
      fails++;
      $display("FAIL gt_latency: got %0d want %0d", lat, LAT_GT);
    end
    tests++;
    if (res !== 3'b001) begin
      fails++;
      $display("FAIL gt_result: lt/eq/gt got %b want 001", res);
    end
    tick();
  endtask

  task automatic test_midrun_start();
    int ndone = 0;
    logic [2:0] res = 3'bxxx;
    bus.a = 8'h10;
    bus.b = 8'h20;
    bus.start = 1'b1;
    for (int cnt = 1; cnt <= 30; cnt++) begin
      tick();
      if (cnt == 1) bus.start = 1'b0;
      if (cnt == 2) begin
        tests++;
        if (bus.busy !== 1'b1 || {bus.lt, bus.eq, bus.gt} !== 3'b001) begin
          fails++;
          $display("FAIL hold_result: busy=%b res=%b want busy=1 res=001",
                   bus.busy, {bus.lt, bus.eq, bus.gt});
        end
      end
      if (cnt == 3) begin
        bus.a = 8'hFF;
        bus.b = 8'h00;
        bus.start = 1'b1;
      end
      if (cnt == 4) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        ndone++;
        res = {bus.lt, bus.eq, bus.gt};
      end
    end
    tests++;
    if (ndone !== 1) begin
      fails++;
      $display("FAIL midrun_done_count: got %0d want 1", ndone);
    end
    tests++;
    if (res !== 3'b100) begin
      fails++;
      $display("FAIL midrun_result: lt/eq/gt got %b want 100", res);
    end
  endtask

  task automatic test_lsb_less();
    int lat;
    logic [2:0] res;
    run_cmp(8'h3C, 8'h3D, lat, res);
    tests++;
    if (lat !== LAT_FULL) begin
      fails++;
      $display("FAIL lsb_latency: got %0d want %0d", lat, LAT_FULL);
    end
    tests++;
    if (res !== 3'b100) begin
      fails++;
      $display("FAIL lsb_result: lt/eq/gt got %b want 100", res);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    int lat;
    int ndone = 0;
    logic [2:0] res;
    // 3C vs 3D runs the full width in both builds, so idx=4 is reachable.
    bus.a = 8'h3C;
    bus.b = 8'h3D;
    bus.start = 1'b1;
    for (int cnt = 1; cnt <= 5; cnt++) begin
      tick();
      if (cnt == 1) bus.start = 1'b0;
    end
    tests++;
    if (bus.busy !== 1'b1 || bus.lt !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: busy=%b lt=%b want busy=1 lt=1", bus.busy, bus.lt);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.busy, bus.done, bus.lt, bus.eq, bus.gt} !== 5'b0) begin
      fails++;
      $display("FAIL reset_midrun: busy/done/lt/eq/gt got %b want 00000",
               {bus.busy, bus.done, bus.lt, bus.eq, bus.gt});
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int cnt = 0; cnt < 12; cnt++) begin
      tick();
      if (bus.done === 1'b1) ndone++;
    end
    tests++;
    if (ndone !== 0) begin
      fails++;
      $display("FAIL reset_no_done: got %0d done pulses want 0", ndone);
    end
    run_cmp(8'h01, 8'h01, lat, res);
    tests++;
    if (lat !== LAT_FULL || res !== 3'b010) begin
      fails++;
      $display("FAIL after_reset_eq: lat=%0d res=%b want lat=%0d res=010",
               lat, res, LAT_FULL);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    int prev = -1;
    logic prev_done = 1'b0;
    int bad_gap = 0;
    int bad_res = 0;
    int consec = 0;
    bus.a = 8'h05;
    bus.b = 8'h09;
    bus.start = 1'b1;
    for (int cnt = 1; cnt <= 45; cnt++) begin
      tick();
      if (cnt == 30) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        if (prev_done) consec++;
        if (prev >= 0 && (cnt - prev) != B2B_PER) bad_gap++;
        if ({bus.lt, bus.eq, bus.gt} !== 3'b100) bad_res++;
        prev = cnt;
        ndone++;
      end
      prev_done = bus.done;
    end
    tests++;
    if (ndone !== B2B_NUM) begin
      fails++;
      $display("FAIL b2b_count: got %0d want %0d", ndone, B2B_NUM);
    end
    tests++;
    if (bad_gap !== 0) begin
      fails++;
      $display("FAIL b2b_period: %0d gaps differ from %0d (want 0)", bad_gap, B2B_PER);
    end
    tests++;
    if (bad_res !== 0) begin
      fails++;
      $display("FAIL b2b_result: %0d pulses without lt=1 (want 0)", bad_res);
    end
    tests++;
    if (consec !== 0) begin
      fails++;
      $display("FAIL b2b_consecutive: got %0d adjacent done cycles want 0", consec);
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_greater();
    test_midrun_start();
    test_lsb_less();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
